alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Host-side initiator for the pipelined ALU. Accepts tagged op commands on a
//  valid/ready stream, drives the ALU's A/B/SEL, and tracks each op through the
//  fixed ALU latency. Captures F/Z/C/V/N into a response FIFO with backpressure,
//  so results are never lost even though the ALU itself cannot stall.
// PARAMETERS
//  WIDTH       12  operand/result width; must equal the ALU's WIDTH
//  LATENCY     2   clock edges from an ALU input change to a valid F/flags (>=1)
//  FIFO_DEPTH  4   response FIFO entries (power of 2, >=LATENCY); also the credit limit
//  TAG_W       4   width of the command tag echoed on the response
// PORTS
//  CLK        in   1      single clock, rising edge
//  RST        in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted when cmd_valid&&cmd_ready at CLK rise
//  cmd_a      in   WIDTH  operand A
//  cmd_b      in   WIDTH  operand B
//  cmd_sel    in   4      opcode (alu_pkg::alu_op_e encoding)
//  cmd_tag    in   TAG_W  caller tag
//  alu_a      out  WIDTH  to ALU A
//  alu_b      out  WIDTH  to ALU B
//  alu_sel    out  4      to ALU SEL
//  alu_f      in   WIDTH  from ALU F
//  alu_z/c/v/n in  1 each from ALU flags
//  rsp_valid  out  1      response at FIFO head
//  rsp_ready  in   1      response popped when rsp_valid&&rsp_ready
//  rsp_f      out  WIDTH  result (forced 0 when rsp_err)
//  rsp_flags  out  4      {Z,C,V,N} (forced 4'b1000 when rsp_err)
//  rsp_tag    out  TAG_W  echoed cmd_tag
//  rsp_err    out  1      illegal opcode (>4'b1100) or DIV with B==0
// BEHAVIOUR
//  - Reset (RST=0, async): alu_a/alu_b/alu_sel=0, in-flight shift reg cleared,
//    FIFO empty, rsp_valid=0, all rsp_* fields=0. In-flight ops are discarded.
//    cmd_ready=1 from the first edge after reset release.
//  - Credits: cnt = in-flight ops + FIFO occupancy.
//    cmd_ready = (cnt < FIFO_DEPTH), decoded from registers only.
//    There is no combinational path rsp_ready->cmd_ready; a pop frees its credit
//    on the following cycle.
//  - Accept at edge k: alu_a/b/sel register the command. {1,tag,err} enters
//    stage 0 of a LATENCY-deep valid/tag/err shift register.
//  - When no op is accepted, alu_* hold their values and stage 0 is loaded with valid=0.
//  - At edge k+LATENCY the last stage is valid: push {alu_f, flags, tag, err}
//    into the FIFO. rsp_valid is high from edge k+LATENCY on. Accept-to-response
//    latency is exactly LATENCY cycles when the FIFO is empty.
//  - Throughput: one command per cycle while credits remain. Back-to-back ops
//    retire in order, one per cycle.
//  - Push and pop in the same cycle: occupancy unchanged, both legal at full.
//    Overflow cannot occur by construction; the design asserts on push-when-full.
//  - Arithmetic: none performed locally. err computed at accept from cmd_sel/cmd_b.
//    Illegal ops are still issued to the ALU; only the response is masked.
//  - Tags are opaque; duplicates allowed; ordering is strictly FIFO.
// STRUCTURE
//  - alu_pkg: alu_op_e enum (ADD=0 .. ZERO=12), OP_LAST=4'd12, flag bit indices.
//  - Sub-module alu_rsp_fifo: sync FIFO with registered head
//    (data, push, pop, full, empty, count).
//  - Top: command regs, latency shift register, credit counter, err decode.
// TESTING
//  - ADD 15+1, tag 3, accept edge k -> rsp_valid from k+2: F=16, flags=0000, tag=3, err=0.
//  - 8 back-to-back ops (SUB 5-15, MUL 3*4, ...), rsp_ready=1 -> in-order
//    responses on consecutive cycles; SUB gives F=12'hFF6, N=1.
//  - rsp_ready=0, stream commands -> exactly FIFO_DEPTH accepted, then cmd_ready=0.
//    One pop -> cmd_ready=1 the next cycle; no response lost or duplicated.
//  - DIV 8/0, then SEL=4'b1110 -> both rsp_err=1, F=0, flags=1000.
//    A following DIV 8/2 -> F=4, err=0.
//  - Assert RST mid-stream with 2 ops in flight -> all outputs reset the same cycle.
//    After release, no stale responses; a new ADD completes normally.
//  - Pop and push in the same cycle at full -> count unchanged, data order preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encoding and flag layout shared by the pipelined ALU and its host-side issuer.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_MUL   = 4'd2,
    ALU_DIV   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOT   = 4'd7,
    ALU_SHL   = 4'd8,
    ALU_SHR   = 4'd9,
    ALU_PASSA = 4'd10,
    ALU_PASSB = 4'd11,
    ALU_ZERO  = 4'd12
  } alu_op_e;

  localparam logic [3:0] OP_LAST = 4'd12;

  // Bit positions inside the {Z,C,V,N} flag nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] ERR_FLAGS = 4'b1000;

  function automatic logic op_is_err(input logic [3:0] sel, input logic b_is_zero);
    return (sel > OP_LAST) || ((sel == ALU_DIV) && b_is_zero);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; head entry is read straight from the storage registers.
module alu_rsp_fifo #(
  parameter int DW    = 21,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && !empty;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: nothing is visible until count says so
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assert property (@(posedge CLK) disable iff (!RST) !(push && full && !pop));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Host-side initiator for the pipelined ALU: issues tagged ops, tracks them through
// the fixed ALU latency and buffers results in a credit-limited response FIFO.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DW    = WIDTH + 4 + TAG_W + 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             err;
  } stage_t;

  stage_t [LATENCY-1:0] pipe_q;
  logic [CNT_W-1:0]     credit_q;
  logic                 armed_q;
  logic                 accept;
  logic                 pop;
  logic                 cmd_err;
  logic [3:0]           alu_flags;
  logic [WIDTH-1:0]     push_f;
  logic [3:0]           push_flags;
  logic [DW-1:0]        fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // Credits cover in-flight ops plus stored responses, so the ALU never outruns the FIFO
  assign cmd_ready = armed_q && (credit_q < CNT_W'(FIFO_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign cmd_err   = op_is_err(cmd_sel, cmd_b == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed_q <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_sel;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= '{valid: accept, tag: cmd_tag, err: cmd_err};
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      credit_q <= '0;
    end else if (accept && !pop) begin
      credit_q <= credit_q + CNT_W'(1);
    end else if (pop && !accept) begin
      credit_q <= credit_q - CNT_W'(1);
    end
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    alu_flags[FLAG_N] = alu_n;
  end

  // Illegal ops still ran on the ALU; only the captured response is masked
  assign push_f     = pipe_q[LATENCY-1].err ? '0 : alu_f;
  assign push_flags = pipe_q[LATENCY-1].err ? ERR_FLAGS : alu_flags;

  alu_rsp_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (pipe_q[LATENCY-1].valid),
    .wdata ({push_f, push_flags, pipe_q[LATENCY-1].tag, pipe_q[LATENCY-1].err}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign {rsp_f, rsp_flags, rsp_tag, rsp_err} = fifo_empty ? {DW{1'b0}} : fifo_rdata;

  assert property (@(posedge CLK) disable iff (!RST) credit_q >= fifo_count);
  assert property (@(posedge CLK) disable iff (!RST) cmd_ready |-> !fifo_full);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural one-register-stage ALU model.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int WIDTH      = 12;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam int NVEC       = 11;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [3:0]       cmd_sel;
  logic [TAG_W-1:0] cmd_tag;
  logic [WIDTH-1:0] alu_a, alu_b, alu_f;
  logic [3:0]       alu_sel;
  logic             alu_z, alu_c, alu_v, alu_n;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  alu_cmd_issuer #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_f(alu_f),
    .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ALU with LATENCY-1 = 1 register stage: result sampled by the issuer at accept+2
  function automatic logic [WIDTH+3:0] alu_model(input logic [3:0] sel,
                                                 input logic [WIDTH-1:0] a, b);
    logic [WIDTH:0]   w;
    logic [WIDTH-1:0] f;
    logic             c, v;
    w = '0; f = '0; c = 1'b0; v = 1'b0;
    case (sel)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b}; f = w[WIDTH-1:0]; c = w[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        w = {1'b0, a} - {1'b0, b}; f = w[WIDTH-1:0]; c = w[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  f = a * b;
      4'd3:  f = (b == '0) ? '0 : a / b;
      4'd4:  f = a & b;
      4'd5:  f = a | b;
      4'd6:  f = a ^ b;
      4'd7:  f = ~a;
      4'd8:  f = a << 1;
      4'd9:  f = a >> 1;
      4'd10: f = a;
      4'd11: f = b;
      default: f = '0;
    endcase
    return {f, (f == '0), c, v, f[WIDTH-1]};
  endfunction

  always @(posedge CLK) {alu_f, alu_z, alu_c, alu_v, alu_n} <= alu_model(alu_sel, alu_a, alu_b);

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  typedef struct {
    logic [3:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] f;
    logic [3:0]       flags;
    logic             err;
  } vec_t;

  rsp_t rx_q[$];
  int   rx_cyc[$];
  vec_t vecs[NVEC];
  int   acc_cyc[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   k, n_acc;

  // Record each pop (valid && ready just before the next rising edge)
  always @(negedge CLK) begin
    #1;
    if (RST && rsp_valid && rsp_ready) begin
      rx_q.push_back('{f: rsp_f, flags: rsp_flags, tag: rsp_tag, err: rsp_err});
      rx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge
  task automatic send(input logic [3:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] tag, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_tag = tag;
    while (!cmd_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'd0, 64'd1);
    acc = cyc + 1;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int w;
    w = 0;
    while (rx_q.size() < n && w < limit) begin
      @(negedge CLK);
      w++;
    end
    #2;
    check("rx_count", 64'(rx_q.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'(ALU_SUB), 12'd5,     12'd15,    4'd1,  12'hFF6, 4'b0101, 1'b0};
    vecs[1]  = '{4'(ALU_MUL), 12'd3,     12'd4,     4'd2,  12'd12,  4'b0000, 1'b0};
    vecs[2]  = '{4'(ALU_ADD), 12'h7FF,   12'h001,   4'd3,  12'h800, 4'b0011, 1'b0};
    vecs[3]  = '{4'(ALU_ADD), 12'hFFF,   12'h001,   4'd4,  12'h000, 4'b1100, 1'b0};
    vecs[4]  = '{4'(ALU_DIV), 12'd100,   12'd7,     4'd5,  12'd14,  4'b0000, 1'b0};
    vecs[5]  = '{4'(ALU_AND), 12'hF0F,   12'h0FF,   4'd6,  12'h00F, 4'b0000, 1'b0};
    vecs[6]  = '{4'(ALU_XOR), 12'hAAA,   12'hAAA,   4'd7,  12'h000, 4'b1000, 1'b0};
    vecs[7]  = '{4'(ALU_OR),  12'h800,   12'h001,   4'd8,  12'h801, 4'b0001, 1'b0};
    vecs[8]  = '{4'(ALU_DIV), 12'd8,     12'd0,     4'd9,  12'h000, 4'b1000, 1'b1};
    vecs[9]  = '{4'b1110,     12'd8,     12'd2,     4'd10, 12'h000, 4'b1000, 1'b1};
    vecs[10] = '{4'(ALU_DIV), 12'd8,     12'd2,     4'd11, 12'd4,   4'b0000, 1'b0};

    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0; rsp_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge CLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu", 64'({alu_a, alu_b, alu_sel}), 64'd0);
    check("rst_rsp_fields", 64'({rsp_f, rsp_flags, rsp_tag, rsp_err}), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Single ADD 15+1, exact two-cycle latency
    send(4'(ALU_ADD), 12'd15, 12'd1, 4'd3, k);
    check("issue_alu_regs", 64'({alu_a, alu_b, alu_sel}), 64'({12'd15, 12'd1, 4'd0}));
    check("add_valid_k", 64'(rsp_valid), 64'd0);
    @(negedge CLK);
    check("add_valid_k1", 64'(rsp_valid), 64'd0);
    @(negedge CLK);
    check("add_valid_k2", 64'(rsp_valid), 64'd1);
    check("add_rsp", 64'({rsp_f, rsp_flags, rsp_tag, rsp_err}),
          64'({12'd16, 4'b0000, 4'd3, 1'b0}));
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("add_popped", 64'(rsp_valid), 64'd0);
    rx_q.delete(); rx_cyc.delete();

    // Back-to-back table vectors with the consumer always ready
    rsp_ready = 1'b1;
    for (int i = 0; i < NVEC; i++)
      send(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].tag, acc_cyc[i]);
    check("b2b_accept_span", 64'(acc_cyc[NVEC-1] - acc_cyc[0]), 64'(NVEC - 1));
    wait_rx(NVEC, 30);
    for (int i = 0; i < NVEC; i++) begin
      if (i < rx_q.size()) begin
        check($sformatf("vec%0d_rsp", i), 64'(rx_q[i]),
              64'({vecs[i].f, vecs[i].flags, vecs[i].tag, vecs[i].err}));
        check($sformatf("vec%0d_latency", i), 64'(rx_cyc[i]), 64'(acc_cyc[i] + LATENCY));
      end
    end
    rsp_ready = 1'b0;
    rx_q.delete(); rx_cyc.delete();

    // Credit limit under backpressure
    n_acc = 0;
    cmd_valid = 1'b1; cmd_sel = 4'(ALU_ADD); cmd_b = '0;
    for (int c = 0; c < 12; c++) begin
      cmd_tag = TAG_W'(n_acc);
      cmd_a   = WIDTH'(n_acc);
      if (cmd_ready) n_acc++;
      @(negedge CLK);
    end
    check("credit_accepts", 64'(n_acc), 64'(FIFO_DEPTH));
    check("credit_ready_low", 64'(cmd_ready), 64'd0);
    check("credit_head", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd0}));
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("credit_freed", 64'(cmd_ready), 64'd1);
    if (cmd_ready) n_acc++;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("credit_refull", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    wait_rx(n_acc, 30);
    repeat (4) @(negedge CLK);
    #2;
    check("credit_no_dup", 64'(rx_q.size()), 64'(FIFO_DEPTH + 1));
    for (int i = 0; i < rx_q.size(); i++)
      check($sformatf("credit_order%0d", i), 64'({rx_q[i].f, rx_q[i].tag}),
            64'({WIDTH'(i), TAG_W'(i)}));
    rsp_ready = 1'b0;
    rx_q.delete(); rx_cyc.delete();

    // Reset with two ops in flight
    rsp_ready = 1'b1;
    send(4'(ALU_ADD), 12'd1, 12'd1, 4'd1, k);
    send(4'(ALU_ADD), 12'd2, 12'd2, 4'd2, k);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_alu", 64'({alu_a, alu_b, alu_sel}), 64'd0);
    check("midrst_rsp", 64'({rsp_valid, rsp_f, rsp_flags, rsp_tag, rsp_err}), 64'd0);
    check("midrst_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    #2;
    check("midrst_no_stale", 64'({rx_q.size() != 0, rsp_valid}), 64'd0);
    send(4'(ALU_ADD), 12'd5, 12'd6, 4'd7, k);
    wait_rx(1, 10);
    if (rx_q.size() > 0) begin
      check("post_rst_rsp", 64'(rx_q[0]), 64'({12'd11, 4'b0000, 4'd7, 1'b0}));
      check("post_rst_latency", 64'(rx_cyc[0]), 64'(k + LATENCY));
    end
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
